// File: rtl/taxi_sfp_link_ctrl.sv
// SFP+ port bring-up / recovery sequencer.
// Debounces module presence, sequences transceiver reset, waits for RX lock,
// retries on lock timeout and latches a fault after repeated failure.
`timescale 1ns/1ps

module taxi_sfp_link_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 125000,
    parameter int unsigned RST_CYCLES      = 64,
    parameter int unsigned LOCK_TIMEOUT    = 12500000,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned RETRY_MAX       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        fault_clear,
    input  logic        sfp_npres,
    input  logic        sfp_los,
    input  logic        rx_status,
    output logic        sfp_tx_disable,
    output logic        xcvr_rst,
    output logic        link_up,
    output logic        fault,
    output logic [2:0]  state,
    output logic [7:0]  retry_cnt,
    output logic [15:0] link_drop_cnt
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RST_W = $clog2(RST_CYCLES) + 1;
    localparam int unsigned LCK_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned STB_W = $clog2(STABLE_CYCLES) + 1;

    localparam logic [2:0] ST_ABSENT    = 3'd0;
    localparam logic [2:0] ST_RESET     = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_UP        = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    logic             r_npres_meta, r_npres_sync;
    logic             r_los_meta, r_los_sync;
    logic             r_stat_meta, r_stat_sync;
    logic [2:0]       r_state;
    logic [7:0]       r_retry_cnt;
    logic [15:0]      r_link_drop_cnt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [RST_W-1:0] r_rst_cnt;
    logic [LCK_W-1:0] r_lock_tmr;
    logic [STB_W-1:0] r_stab_cnt;
    logic             r_tx_disable, r_xcvr_rst, r_link_up, r_fault;

    logic             w_present, w_los, w_stat;
    logic             w_enabled, w_deb_done, w_rst_done, w_stable_done, w_lock_timeout;
    logic [2:0]       w_next_state;
    logic [7:0]       w_next_retry;
    logic             w_drop_inc, w_state_chg, w_hold_off;

    assign w_present = ~r_npres_sync;
    assign w_los     = r_los_sync;
    assign w_stat    = r_stat_sync;
    assign w_enabled = w_present & cfg_enable;

    assign w_deb_done     = (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign w_rst_done     = (r_rst_cnt == RST_W'(RST_CYCLES - 1));
    assign w_stable_done  = w_stat && (r_stab_cnt == STB_W'(STABLE_CYCLES - 1));
    // The lock timer sits at zero while dark, so timeout only fires with light present
    assign w_lock_timeout = !w_los && (r_lock_tmr == LCK_W'(LOCK_TIMEOUT - 1));

    // Two-flop synchronisers; reset to the "absent, dark, no lock" values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_npres_meta <= 1'b1;
            r_npres_sync <= 1'b1;
            r_los_meta   <= 1'b1;
            r_los_sync   <= 1'b1;
            r_stat_meta  <= 1'b0;
            r_stat_sync  <= 1'b0;
        end else begin
            r_npres_meta <= sfp_npres;
            r_npres_sync <= r_npres_meta;
            r_los_meta   <= sfp_los;
            r_los_sync   <= r_los_meta;
            r_stat_meta  <= rx_status;
            r_stat_sync  <= r_stat_meta;
        end
    end

    // Next-state / retry decision; removal or disable overrides everything
    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry_cnt;
        w_drop_inc   = 1'b0;
        if (!w_enabled) begin
            w_next_state = ST_ABSENT;
            w_next_retry = '0;
        end else begin
            case (r_state)
                ST_ABSENT: begin
                    if (w_deb_done) w_next_state = ST_RESET;
                end
                ST_RESET: begin
                    if (w_rst_done) w_next_state = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_stable_done) begin
                        w_next_state = ST_UP;
                        w_next_retry = '0;
                    end else if (w_lock_timeout) begin
                        if (r_retry_cnt == 8'(RETRY_MAX)) begin
                            w_next_state = ST_FAULT;
                        end else begin
                            w_next_state = ST_RESET;
                            w_next_retry = r_retry_cnt + 8'd1;
                        end
                    end
                end
                ST_UP: begin
                    if (!w_stat || w_los) begin
                        w_next_state = ST_RESET;
                        w_drop_inc   = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear) begin
                        w_next_state = ST_RESET;
                        w_next_retry = '0;
                    end
                end
                default: w_next_state = ST_ABSENT;
            endcase
        end
    end

    assign w_state_chg = (w_next_state != r_state);
    assign w_hold_off  = (w_next_state == ST_ABSENT) || (w_next_state == ST_RESET) ||
                         (w_next_state == ST_FAULT);

    // State, retry and drop counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_ABSENT;
            r_retry_cnt     <= '0;
            r_link_drop_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_retry_cnt <= w_next_retry;
            if (w_drop_inc && (r_link_drop_cnt != '1)) r_link_drop_cnt <= r_link_drop_cnt + 16'd1;
        end
    end

    // Per-state timers; each is zero outside its own state and on any state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_cnt  <= '0;
            r_rst_cnt  <= '0;
            r_lock_tmr <= '0;
            r_stab_cnt <= '0;
        end else begin
            if (w_state_chg || r_state != ST_ABSENT || !w_enabled) r_deb_cnt <= '0;
            else r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            if (w_state_chg || r_state != ST_RESET) r_rst_cnt <= '0;
            else r_rst_cnt <= r_rst_cnt + RST_W'(1);
            if (w_state_chg || r_state != ST_WAIT_LOCK || w_los) r_lock_tmr <= '0;
            else r_lock_tmr <= r_lock_tmr + LCK_W'(1);
            if (w_state_chg || r_state != ST_WAIT_LOCK || !w_stat) r_stab_cnt <= '0;
            else r_stab_cnt <= r_stab_cnt + STB_W'(1);
        end
    end

    // Moore outputs decoded from the next state so they align with r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_disable <= 1'b1;
            r_xcvr_rst   <= 1'b1;
            r_link_up    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_tx_disable <= w_hold_off;
            r_xcvr_rst   <= w_hold_off;
            r_link_up    <= (w_next_state == ST_UP);
            r_fault      <= (w_next_state == ST_FAULT);
        end
    end

    assign sfp_tx_disable = r_tx_disable;
    assign xcvr_rst       = r_xcvr_rst;
    assign link_up        = r_link_up;
    assign fault          = r_fault;
    assign state          = r_state;
    assign retry_cnt      = r_retry_cnt;
    assign link_drop_cnt  = r_link_drop_cnt;

endmodule

// File: tb/tb_taxi_sfp_link_ctrl.sv
// Self-checking bench for taxi_sfp_link_ctrl with small timing parameters.
`timescale 1ns/1ps

module tb_taxi_sfp_link_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RSTC = 3;
    localparam int unsigned LT   = 10;
    localparam int unsigned STB  = 2;
    localparam int unsigned RMAX = 2;

    localparam logic [2:0] S_ABSENT = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WL     = 3'd2;
    localparam logic [2:0] S_UP     = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic        clk = 1'b0;
    logic        rst, cfg_enable, fault_clear, sfp_npres, sfp_los, rx_status;
    logic        sfp_tx_disable, xcvr_rst, link_up, fault;
    logic [2:0]  state;
    logic [7:0]  retry_cnt;
    logic [15:0] link_drop_cnt;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    taxi_sfp_link_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RST_CYCLES(RSTC),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(STB),
        .RETRY_MAX(RMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_enable(cfg_enable),
        .fault_clear(fault_clear),
        .sfp_npres(sfp_npres),
        .sfp_los(sfp_los),
        .rx_status(rx_status),
        .sfp_tx_disable(sfp_tx_disable),
        .xcvr_rst(xcvr_rst),
        .link_up(link_up),
        .fault(fault),
        .state(state),
        .retry_cnt(retry_cnt),
        .link_drop_cnt(link_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts cycles until the given state appears (bounded) and checks the count
    task automatic wait_state(input string tag, input logic [2:0] exp_st, input int unsigned exp_cyc);
        int unsigned c = 0;
        while (c < exp_cyc + 8) begin
            tick(1);
            c++;
            if (state == exp_st) break;
        end
        chk(tag, c, exp_cyc);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".state"}, state, S_ABSENT);
        chk({tag, ".tx_disable"}, sfp_tx_disable, 1);
        chk({tag, ".xcvr_rst"}, xcvr_rst, 1);
        chk({tag, ".link_up"}, link_up, 0);
        chk({tag, ".fault"}, fault, 0);
        chk({tag, ".retry_cnt"}, retry_cnt, 0);
        chk({tag, ".drop_cnt"}, link_drop_cnt, 0);
    endtask

    // Presence pattern (bit j = present, driven after cycle j, then present forever).
    // RESET is expected 3 cycles after the pin cycle completing the first run of DEB.
    task automatic deb_trial(input string tag, input logic [15:0] pat);
        int unsigned run = 0;
        int unsigned exp_cyc = 0;
        int unsigned bad = 0;
        for (int unsigned j = 0; j < 40 && exp_cyc == 0; j++) begin
            if (j >= 16 || pat[j[3:0]]) run++;
            else run = 0;
            if (run == DEB) exp_cyc = j + 3;
        end
        for (int unsigned j = 0; j < 40; j++) begin
            sfp_npres = (j < 16) ? !pat[j[3:0]] : 1'b0;
            tick(1);
            if (j + 1 == exp_cyc) begin
                chk(tag, state, S_RESET);
                break;
            end
            if (state != S_ABSENT) bad++;
        end
        chk({tag, "_early"}, bad, 0);
        sfp_npres = 1'b1;
        wait_state({tag, "_exit"}, S_ABSENT, 3);
        tick(3);
    endtask

    initial begin
        int unsigned bad;
        int unsigned k, m, run, exp_cyc, n_drops;
        logic seen;

        rst = 1'b1; cfg_enable = 1'b0; fault_clear = 1'b0;
        sfp_npres = 1'b1; sfp_los = 1'b1; rx_status = 1'b0;
        #1;
        check_reset_outs("por");
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("idle_disabled", state, S_ABSENT);
        cfg_enable = 1'b1; sfp_los = 1'b0; rx_status = 1'b1;
        tick(4);
        chk("idle_no_module", state, S_ABSENT);

        // Bring-up: pin edge -> RESET 6, WAIT_LOCK 3 later, UP 2 later
        sfp_npres = 1'b0;
        wait_state("bringup_reset", S_RESET, DEB + 2);
        chk("bringup_reset_xrst", xcvr_rst, 1);
        chk("bringup_reset_txdis", sfp_tx_disable, 1);
        wait_state("bringup_wait_lock", S_WL, RSTC);
        chk("bringup_wl_xrst", xcvr_rst, 0);
        chk("bringup_wl_txdis", sfp_tx_disable, 0);
        wait_state("bringup_up", S_UP, STB);
        chk("bringup_link_up", link_up, 1);
        chk("bringup_up_txdis", sfp_tx_disable, 0);

        // Disable overrides immediately (not synchronised)
        cfg_enable = 1'b0;
        wait_state("cfg_off", S_ABSENT, 1);
        chk("cfg_off_link_up", link_up, 0);
        chk("cfg_off_txdis", sfp_tx_disable, 1);
        cfg_enable = 1'b1; sfp_npres = 1'b1;
        tick(5);
        chk("cfg_reenable_absent", state, S_ABSENT);

        // Debounce: directed bounce (3 present, 1 absent, present) then random
        deb_trial("bounce_directed", 16'hFFF7);
        for (int t = 0; t < 3; t++) deb_trial("bounce_random", 16'($urandom | $urandom));

        // Retry to fault
        rx_status = 1'b0;
        tick(3);
        sfp_npres = 1'b0;
        wait_state("fault_seq_reset", S_RESET, DEB + 2);
        for (int unsigned p = 0; p <= RMAX; p++) begin
            wait_state("retry_wl", S_WL, RSTC);
            chk("retry_wl_cnt", retry_cnt, p);
            chk("retry_wl_txdis", sfp_tx_disable, 0);
            if (p < RMAX) begin
                wait_state("retry_timeout", S_RESET, LT);
                chk("retry_inc", retry_cnt, p + 1);
            end else begin
                wait_state("fault_entry", S_FAULT, LT);
                chk("fault_flag", fault, 1);
                chk("fault_txdis", sfp_tx_disable, 1);
                chk("fault_xrst", xcvr_rst, 1);
                chk("fault_retry", retry_cnt, RMAX);
            end
        end
        tick($urandom_range(1, 8));
        chk("fault_sticky", state, S_FAULT);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        chk("fault_clear_state", state, S_RESET);
        chk("fault_clear_retry", retry_cnt, 0);
        chk("fault_clear_flag", fault, 0);

        // LOS hold: no timeout while dark, timeout LT cycles after los_s falls
        sfp_los = 1'b1;
        wait_state("los_wl", S_WL, RSTC);
        bad = 0;
        for (int t = 0; t < 50; t++) begin
            tick(1);
            if (state != S_WL) bad++;
        end
        chk("los_hold_no_timeout", bad, 0);
        chk("los_hold_retry", retry_cnt, 0);
        sfp_los = 1'b0;
        wait_state("los_release_timeout", S_RESET, LT + 2);
        chk("los_release_retry", retry_cnt, 1);

        // Random LOS interruption mid-WAIT_LOCK; stray fault_clear must be ignored
        wait_state("los_rand_wl", S_WL, RSTC);
        k = $urandom_range(0, 7);
        m = $urandom_range(1, 4);
        run = 0; exp_cyc = 0;
        for (int unsigned d = 1; d < 80 && exp_cyc == 0; d++) begin
            seen = (d >= 3) && (d - 3 >= k) && (d - 3 < k + m);
            if (seen) run = 0;
            else run++;
            if (run == LT) exp_cyc = d;
        end
        bad = 0;
        for (int unsigned t = 0; t < 60; t++) begin
            sfp_los = (t >= k) && (t < k + m);
            fault_clear = (t == 1);
            tick(1);
            if (t + 1 == exp_cyc) begin
                chk("los_rand_timeout", state, S_RESET);
                break;
            end
            if (state != S_WL) bad++;
        end
        sfp_los = 1'b0; fault_clear = 1'b0;
        chk("los_rand_early", bad, 0);
        chk("los_rand_retry", retry_cnt, 2);

        // Lock and link drops
        rx_status = 1'b1;
        wait_state("relock_wl", S_WL, RSTC);
        wait_state("relock_up", S_UP, STB);
        chk("relock_retry_clear", retry_cnt, 0);
        n_drops = $urandom_range(2, 4);
        for (int unsigned i = 1; i <= n_drops; i++) begin
            if ($urandom_range(0, 1) == 0) rx_status = 1'b0;
            else sfp_los = 1'b1;
            tick(1);
            rx_status = 1'b1; sfp_los = 1'b0;
            wait_state("drop_reset", S_RESET, 2);
            chk("drop_link_up", link_up, 0);
            chk("drop_cnt", link_drop_cnt, i);
            wait_state("drop_wl", S_WL, RSTC);
            wait_state("drop_up", S_UP, STB);
        end

        // Saturation of the drop counter
        tick(1);
        force dut.r_link_drop_cnt = 16'hFFFF;
        tick(1);
        release dut.r_link_drop_cnt;
        tick(1);
        chk("drop_preload", link_drop_cnt, 16'hFFFF);
        rx_status = 1'b0;
        tick(1);
        rx_status = 1'b1;
        wait_state("sat_drop_reset", S_RESET, 2);
        chk("drop_saturate", link_drop_cnt, 16'hFFFF);
        wait_state("sat_wl", S_WL, RSTC);
        wait_state("sat_up", S_UP, STB);

        // Removal while UP
        sfp_npres = 1'b1;
        wait_state("remove_up", S_ABSENT, 3);
        chk("remove_up_retry", retry_cnt, 0);
        chk("remove_up_link", link_up, 0);
        chk("remove_up_txdis", sfp_tx_disable, 1);
        chk("remove_up_xrst", xcvr_rst, 1);
        chk("remove_up_nodrop", link_drop_cnt, 16'hFFFF);

        // Removal decided in the same cycle as a lock timeout
        rx_status = 1'b0;
        tick(3);
        sfp_npres = 1'b0;
        wait_state("rt_reset", S_RESET, DEB + 2);
        wait_state("rt_wl1", S_WL, RSTC);
        wait_state("rt_timeout1", S_RESET, LT);
        chk("rt_retry1", retry_cnt, 1);
        wait_state("rt_wl2", S_WL, RSTC);
        tick(LT - 3);
        sfp_npres = 1'b1;
        wait_state("remove_at_timeout", S_ABSENT, 3);
        chk("remove_at_timeout_retry", retry_cnt, 0);

        // Asynchronous reset mid-WAIT_LOCK
        tick(3);
        sfp_npres = 1'b0;
        wait_state("ar_reset", S_RESET, DEB + 2);
        wait_state("ar_wl1", S_WL, RSTC);
        wait_state("ar_timeout", S_RESET, LT);
        wait_state("ar_wl2", S_WL, RSTC);
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs("async_rst");
        tick(2);
        chk("async_rst_held", state, S_ABSENT);
        #2;
        rst = 1'b0;
        wait_state("post_rst_rebringup", S_RESET, DEB + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
